// File: rtl/bsc_pkg.sv
// Shared definitions for the bit-serial sequencer: opcodes, FSM states,
// instruction field offsets and small decode helpers.
package bsc_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_LDI = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;

    localparam int RD_LSB  = 0;
    localparam int RS1_LSB = 2;
    localparam int RS2_LSB = 4;
    localparam int IMM_LSB = 4;
    localparam int IMM_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        DONE
    } state_t;

    // Opcodes 8..15 are the illegal half of the encoding space.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic op_runs_datapath(input logic [3:0] op);
        return !op[3] && (op != OP_NOP);
    endfunction

    // Immediate bit for a datapath bit position; positions past imm8 read as 0.
    function automatic logic imm_bit_at(input logic [IMM_W-1:0] imm, input int idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < IMM_W; i++) begin
            if (idx == i) b = imm[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bit_serial_sequencer_if.sv
// Instruction-in / per-bit-control-out bundle between the instruction loader
// (master) and the sequencer (slave).
interface bit_serial_sequencer_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic             inst_valid;
    logic [3:0]       opcode;
    logic [11:0]      instr;
    logic             step;

    logic             busy;
    logic             shift_en;
    logic             wb_en;
    logic [2:0]       alu_op;
    logic [SEL_W-1:0] rs1_sel;
    logic [SEL_W-1:0] rs2_sel;
    logic [SEL_W-1:0] rd_sel;
    logic             op_b_imm;
    logic             imm_bit;
    logic [IDX_W-1:0] bit_idx;
    logic             carry_init;
    logic             first_bit;
    logic             last_bit;
    logic             done;
    logic             illegal;
    logic             overrun;

    modport master (
        output inst_valid, opcode, instr, step,
        input  busy, shift_en, wb_en, alu_op, rs1_sel, rs2_sel, rd_sel, op_b_imm,
               imm_bit, bit_idx, carry_init, first_bit, last_bit, done, illegal, overrun
    );

    modport slave (
        input  inst_valid, opcode, instr, step,
        output busy, shift_en, wb_en, alu_op, rs1_sel, rs2_sel, rd_sel, op_b_imm,
               imm_bit, bit_idx, carry_init, first_bit, last_bit, done, illegal, overrun
    );

endinterface

// File: rtl/bit_serial_sequencer_counter.sv
// Bit-index counter: synchronous load, counts up under enable and stops at
// WIDTH-1, with a terminal-count flag for the last bit.
module bit_counter #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [IDX_W-1:0] load_val,
    input  logic             en,
    output logic [IDX_W-1:0] count,
    output logic             tc
);

    assign tc = (count == IDX_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bit_serial_sequencer.sv
// Control FSM for the bit-serial datapath: one instruction = DECODE, WIDTH EXEC bit cycles (LSB first), DONE.
// Build option SEQ_SINGLE_STEP_EN: EXEC advances only in cycles where step=1.
module bit_serial_sequencer
    import bsc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
) (
    input logic                   clk,
    input logic                   rst,
    bit_serial_sequencer_if.slave bus
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int SEL_W = $clog2(NUM_REGS);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             advance;
    logic             tc;
    logic [IDX_W-1:0] bit_idx;
    logic [3:0]       op_q;
    logic [SEL_W-1:0] rd_q;
    logic [SEL_W-1:0] rs1_q;
    logic [SEL_W-1:0] rs2_q;
    logic [IMM_W-1:0] imm_q;
    logic             busy_q;
    logic             exec_q;
    logic             done_q;
    logic             carry_q;
    logic             imm_sel_q;
    logic             illegal_q;
    logic             overrun_q;

    assign accept = (state == IDLE) && bus.inst_valid;

`ifdef SEQ_SINGLE_STEP_EN
    assign advance = bus.step;
`else
    logic step_unused;
    assign step_unused = bus.step;
    assign advance     = 1'b1;
`endif

    // NOTE: state_nxt gets a default before the case so no path through this process infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.inst_valid) state_nxt = DECODE;
            DECODE:  state_nxt = op_runs_datapath(op_q) ? EXEC : DONE;
            EXEC:    if (advance && tc) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: latched instruction fields are reset as well, so every output reads 0 straight out of reset.
            state     <= IDLE;
            busy_q    <= 1'b0;
            exec_q    <= 1'b0;
            done_q    <= 1'b0;
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            carry_q   <= 1'b0;
            imm_sel_q <= 1'b0;
            illegal_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != IDLE);
            exec_q <= (state_nxt == EXEC);
            done_q <= (state_nxt == DONE);
            if (accept) begin
                op_q      <= bus.opcode;
                rd_q      <= bus.instr[RD_LSB +: SEL_W];
                rs1_q     <= bus.instr[RS1_LSB +: SEL_W];
                rs2_q     <= bus.instr[RS2_LSB +: SEL_W];
                imm_q     <= bus.instr[IMM_LSB +: IMM_W];
                carry_q   <= (bus.opcode == OP_SUB);
                imm_sel_q <= (bus.opcode == OP_LDI);
                illegal_q <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                // Any inst_valid outside IDLE is dropped; the fields above stay as they are.
                if (bus.inst_valid) overrun_q <= 1'b1;
                if ((state == DECODE) && op_is_illegal(op_q)) illegal_q <= 1'b1;
            end
        end
    end

    // Held at 0 outside EXEC so every instruction starts at bit 0.
    bit_counter #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (state != EXEC),
        .load_val ('0),
        .en       ((state == EXEC) && advance),
        .count    (bit_idx),
        .tc       (tc)
    );

    assign bus.busy       = busy_q;
    assign bus.shift_en   = exec_q && advance;
    assign bus.wb_en      = exec_q && advance;
    assign bus.alu_op     = op_q[2:0];
    assign bus.rd_sel     = rd_q;
    assign bus.rs1_sel    = rs1_q;
    assign bus.rs2_sel    = rs2_q;
    assign bus.op_b_imm   = imm_sel_q;
    assign bus.carry_init = carry_q;
    assign bus.bit_idx    = bit_idx;
    assign bus.first_bit  = (state == EXEC) && (bit_idx == '0);
    assign bus.last_bit   = (state == EXEC) && tc;
    assign bus.imm_bit    = (state == EXEC) && imm_bit_at(imm_q, 32'(bit_idx));
    assign bus.done       = done_q;
    assign bus.illegal    = illegal_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_bit_serial_sequencer.sv
// Bench for bit_serial_sequencer: directed instruction scenarios plus random traffic,
// checked every cycle against a transaction-level model counting cycles and bits per instruction.
module tb_bit_serial_sequencer;
    import bsc_pkg::*;

    localparam int WIDTH    = 8;
    localparam int NUM_REGS = 4;
`ifdef SEQ_SINGLE_STEP_EN
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit_serial_sequencer_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) bus ();

    bit_serial_sequencer #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests  = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an accepted instruction is described by its age in cycles and bits completed.
    bit          m_active     = 1'b0;
    int          m_age        = 0;
    int          m_bits       = 0;
    logic [3:0]  m_op         = '0;
    logic [11:0] m_instr      = '0;
    bit          m_legal_exec = 1'b0;
    bit          m_illegal    = 1'b0;
    bit          m_overrun    = 1'b0;

    function automatic bit m_in_exec();
        return m_active && m_legal_exec && (m_age >= 2) && (m_bits < WIDTH);
    endfunction

    function automatic bit m_in_done();
        return m_active && (m_age >= 2) && (!m_legal_exec || (m_bits == WIDTH));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active     <= 1'b0;
            m_age        <= 0;
            m_bits       <= 0;
            m_op         <= '0;
            m_instr      <= '0;
            m_legal_exec <= 1'b0;
            m_illegal    <= 1'b0;
            m_overrun    <= 1'b0;
        end else if (!m_active) begin
            if (bus.inst_valid === 1'b1) begin
                m_active     <= 1'b1;
                m_age        <= 1;
                m_bits       <= 0;
                m_op         <= bus.opcode;
                m_instr      <= bus.instr;
                m_legal_exec <= (bus.opcode >= 4'd1) && (bus.opcode <= 4'd7);
                m_illegal    <= 1'b0;
                m_overrun    <= 1'b0;
            end
        end else begin
            if (bus.inst_valid === 1'b1) m_overrun <= 1'b1;
            if ((m_age == 1) && (m_op > 4'd7)) m_illegal <= 1'b1;
            if (m_in_done()) begin
                m_active <= 1'b0;
            end else begin
                if (m_in_exec() && (!STEP_MODE || bus.step)) m_bits <= m_bits + 1;
                m_age <= m_age + 1;
            end
        end
    end

    task automatic compare_outputs();
        bit         ex;
        bit         dn;
        bit         adv;
        int         idx;
        logic [7:0] imm;
        ex  = m_in_exec();
        dn  = m_in_done();
        adv = !STEP_MODE || bus.step;
        idx = (m_active && m_legal_exec) ? ((m_bits < WIDTH) ? m_bits : WIDTH - 1) : 0;
        imm = m_instr[11:4];
        check("busy",       32'(bus.busy),       32'(m_active));
        check("shift_en",   32'(bus.shift_en),   32'(ex && adv));
        check("wb_en",      32'(bus.wb_en),      32'(ex && adv));
        check("done",       32'(bus.done),       32'(dn));
        check("bit_idx",    32'(bus.bit_idx),    32'(idx));
        check("first_bit",  32'(bus.first_bit),  32'(ex && (m_bits == 0)));
        check("last_bit",   32'(bus.last_bit),   32'(ex && (m_bits == WIDTH - 1)));
        check("imm_bit",    32'(bus.imm_bit),    32'(ex && (idx < 8) && imm[idx[2:0]]));
        check("alu_op",     32'(bus.alu_op),     32'(m_op[2:0]));
        check("rd_sel",     32'(bus.rd_sel),     32'(m_instr[1:0]));
        check("rs1_sel",    32'(bus.rs1_sel),    32'(m_instr[3:2]));
        check("rs2_sel",    32'(bus.rs2_sel),    32'(m_instr[5:4]));
        check("op_b_imm",   32'(bus.op_b_imm),   32'(m_op == OP_LDI));
        check("carry_init", 32'(bus.carry_init), 32'(m_op == OP_SUB));
        check("illegal",    32'(bus.illegal),    32'(m_illegal));
        check("overrun",    32'(bus.overrun),    32'(m_overrun));
    endtask

    always @(negedge clk) begin
        if (check_en) compare_outputs();
    end

    // Called at posedge+2 while idle; returns at posedge+2 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [11:0] ins);
        bus.opcode     = op;
        bus.instr      = ins;
        bus.inst_valid = 1'b1;
        @(posedge clk);
        #2;
        bus.inst_valid = 1'b0;
        bus.opcode     = 4'($urandom_range(0, 15));
        bus.instr      = 12'($urandom);
    endtask

    // Cycle n counts from the accept cycle (n=0). Optionally injects an extra inst_valid at cycle inject_at.
    task automatic run_until_done(input int step_period, input int inject_at,
                                  output int lat, output int shifts, output int last_shift,
                                  output logic [WIDTH-1:0] seq, output bit carry_first);
        lat         = -1;
        shifts      = 0;
        last_shift  = -1;
        seq         = '0;
        carry_first = 1'b0;
        for (int n = 1; n <= 64; n++) begin
            bus.step = ((n % step_period) == 0);
            if (n == inject_at) begin
                bus.inst_valid = 1'b1;
                bus.opcode     = OP_OR;
                bus.instr      = 12'h000;
            end else begin
                bus.inst_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.shift_en === 1'b1) begin
                if (shifts < WIDTH) seq[shifts[2:0]] = bus.imm_bit;
                shifts++;
                last_shift = n;
            end
            if (bus.first_bit === 1'b1) carry_first = bus.carry_init;
            if (bus.done === 1'b1) lat = n;
            @(posedge clk);
            #2;
            if (lat >= 0) break;
        end
        bus.inst_valid = 1'b0;
        bus.step       = 1'b1;
        if (lat < 0) check("done_timeout", 32'(lat), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int               lat;
        int               shifts;
        int               last_shift;
        logic [WIDTH-1:0] seq;
        bit               cfirst;
        bit               found;
        bit               seen_done;

        bus.inst_valid = 1'b0;
        bus.opcode     = '0;
        bus.instr      = '0;
        bus.step       = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst      = 1'b0;
        check_en = 1'b1;

        @(negedge clk);
        check("reset_busy",    32'(bus.busy),    32'(0));
        check("reset_done",    32'(bus.done),    32'(0));
        check("reset_bit_idx", 32'(bus.bit_idx), 32'(0));
        check("reset_rd_sel",  32'(bus.rd_sel),  32'(0));
        @(posedge clk);
        #2;

        // ADD r3 <= r2 + r1
        issue(OP_ADD, 12'h01B);
        run_until_done(1, 0, lat, shifts, last_shift, seq, cfirst);
        check("add_latency", 32'(lat),         32'(10));
        check("add_shifts",  32'(shifts),      32'(8));
        check("add_carry",   32'(cfirst),      32'(0));
        check("add_rd",      32'(bus.rd_sel),  32'(3));
        check("add_rs1",     32'(bus.rs1_sel), 32'(2));
        check("add_rs2",     32'(bus.rs2_sel), 32'(1));
        check("add_alu_op",  32'(bus.alu_op),  32'(1));

        issue(OP_SUB, 12'h3C6);
        run_until_done(1, 0, lat, shifts, last_shift, seq, cfirst);
        check("sub_carry",   32'(cfirst), 32'(1));
        check("sub_latency", 32'(lat),    32'(10));

        issue(OP_LDI, 12'hA52);
        run_until_done(1, 0, lat, shifts, last_shift, seq, cfirst);
        check("ldi_imm_seq",  32'(seq),          32'(8'hA5));
        check("ldi_op_b_imm", 32'(bus.op_b_imm), 32'(1));
        check("ldi_shifts",   32'(shifts),       32'(8));

        issue(OP_NOP, 12'hFFF);
        run_until_done(1, 0, lat, shifts, last_shift, seq, cfirst);
        check("nop_latency", 32'(lat),    32'(2));
        check("nop_shifts",  32'(shifts), 32'(0));

        issue(4'hC, 12'h123);
        run_until_done(1, 0, lat, shifts, last_shift, seq, cfirst);
        check("ill_latency", 32'(lat),         32'(2));
        check("ill_shifts",  32'(shifts),      32'(0));
        check("ill_flag",    32'(bus.illegal), 32'(1));

        issue(OP_AND, 12'h055);
        run_until_done(1, 0, lat, shifts, last_shift, seq, cfirst);
        check("ill_cleared", 32'(bus.illegal), 32'(0));
        check("and_latency", 32'(lat),         32'(10));

        // Second inst_valid at bit_idx=5 (cycle 7)
        issue(OP_XOR, 12'h2E7);
        run_until_done(1, 7, lat, shifts, last_shift, seq, cfirst);
        check("ovr_flag",    32'(bus.overrun), 32'(1));
        check("ovr_rd_sel",  32'(bus.rd_sel),  32'(3));
        check("ovr_alu_op",  32'(bus.alu_op),  32'(5));
        check("ovr_latency", 32'(lat),         32'(10));

        // inst_valid during DONE (cycle 10) is also dropped
        issue(OP_MOV, 12'h00D);
        check("ovr_cleared", 32'(bus.overrun), 32'(0));
        run_until_done(1, 10, lat, shifts, last_shift, seq, cfirst);
        check("ovr_done_flag", 32'(bus.overrun), 32'(1));
        check("mov_latency",   32'(lat),         32'(10));

        // Reset mid-EXEC at bit_idx=3
        issue(OP_ADD, 12'h0E4);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if ((bus.bit_idx == 3'd3) && (bus.shift_en === 1'b1)) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #2;
            end
        end
        check("rm_reached_bit3", 32'(found), 32'(1));
        #1 rst = 1'b1;
        #1;
        check("rm_busy",     32'(bus.busy),     32'(0));
        check("rm_shift_en", 32'(bus.shift_en), 32'(0));
        check("rm_bit_idx",  32'(bus.bit_idx),  32'(0));
        check("rm_alu_op",   32'(bus.alu_op),   32'(0));
        check("rm_rd_sel",   32'(bus.rd_sel),   32'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check("rm_no_done", 32'(seen_done), 32'(0));
        @(posedge clk);
        #2;

`ifdef SEQ_SINGLE_STEP_EN
        // step every 3rd cycle: bits advance at cycles 3,6,...,24; DONE in cycle 25
        issue(OP_ADD, 12'h01B);
        run_until_done(3, 0, lat, shifts, last_shift, seq, cfirst);
        check("step_shifts",     32'(shifts), 32'(8));
        check("step_latency",    32'(lat),    32'(25));
        check("step_done_after", 32'(lat),    32'(last_shift + 1));
`endif

        for (int c = 0; c < 3000; c++) begin
            bus.inst_valid = ($urandom_range(0, 5) == 0);
            bus.opcode     = 4'($urandom_range(0, 15));
            bus.instr      = 12'($urandom);
            bus.step       = 1'($urandom_range(0, 1));
            rst            = ($urandom_range(0, 399) == 0);
            @(posedge clk);
            #2;
        end
        rst            = 1'b0;
        bus.inst_valid = 1'b0;
        bus.step       = 1'b1;
        repeat (40) @(posedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
